// File: rtl/ss_chan_buf.sv
// Per-channel stream buffer: source FIFO (stream -> module) and destination FIFO (module -> stream).
// Define SS_CHAN_BUF_FWFT_EN for first-word-fall-through read ports; the default is registered read.
module ss_chan_buf #(
  parameter int DW        = 64,
  parameter int AW        = 4,
  parameter int START_LVL = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [23:0]   dc,
  input  logic          ss_xfer0,
  input  logic [DW-1:0] ss_dat0,
  input  logic          ss_last0,
  output logic          ss_stop0,
  output logic          ss_start0,
  output logic          ss_end0,
  input  logic          ss_xfer1,
  output logic [DW-1:0] ss_dat1,
  output logic          ss_stop1,
  output logic          ss_start1,
  output logic          ss_end1,
  input  logic          m_reset,
  input  logic          m_src_getn,
  output logic [DW-1:0] m_src,
  output logic          m_src_last,
  output logic          m_src_almost_empty,
  output logic          m_src_empty,
  input  logic          m_dst_putn,
  input  logic [DW-1:0] m_dst,
  input  logic          m_dst_last,
  output logic          m_dst_almost_full,
  output logic          m_dst_full,
  input  logic          m_endn,
  output logic [AW:0]   src_cnt,
  output logic [AW:0]   dst_cnt,
  output logic          ovf
);
  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AFULL = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_START = (AW+1)'(START_LVL);
  localparam logic [AW-1:0] PTR_ONE   = (AW)'(1);

  // Channel 0 is the source FIFO, channel 1 the destination FIFO.
  logic          push_a    [2];
  logic          pop_a     [2];
  logic [DW:0]   wdata_a   [2];
  logic [DW:0]   rdata_a   [2];
  logic [AW:0]   cnt_a     [2];
  logic [AW:0]   cnt_nxt_a [2];
  logic          drop_a    [2];
  logic [23:0]   word_cnt_r;
  logic          src_acc_s;

  assign push_a[0]  = ss_xfer0;
  assign pop_a[0]   = !m_src_getn;
  assign wdata_a[0] = {ss_last0, ss_dat0};
  assign push_a[1]  = !m_dst_putn;
  assign pop_a[1]   = ss_xfer1;
  assign wdata_a[1] = {m_dst_last, m_dst};

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [DW:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic [AW:0]   cnt_nxt_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [DW:0]   rdata_s;

    // A full FIFO drops the push even when a pop frees a slot in the same cycle
    always_comb begin
      push_ok_s = push_a[ch] && (cnt_r != CNT_FULL);
      pop_ok_s  = pop_a[ch] && (cnt_r != CNT_ZERO);
      if (push_ok_s && !pop_ok_s) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else if (pop_ok_s && !push_ok_s) begin
        cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i || m_reset) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        cnt_r    <= CNT_ZERO;
      end else begin
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_ok_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        cnt_r <= cnt_nxt_s;
      end
    end

    // Storage is not reset; pointers and occupancy alone define which entries are valid
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i && !m_reset && push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata_a[ch];
      end
    end

`ifdef SS_CHAN_BUF_FWFT_EN
    always_comb begin
      if (cnt_r != CNT_ZERO) begin
        rdata_s = mem_r[rd_ptr_r];
      end else begin
        rdata_s = {(DW+1){1'b0}};
      end
    end
`else
    logic [DW:0] rdata_r;

    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i || m_reset) begin
        rdata_r <= {(DW+1){1'b0}};
      end else if (pop_ok_s) begin
        rdata_r <= mem_r[rd_ptr_r];
      end
    end

    assign rdata_s = rdata_r;
`endif

    assign rdata_a[ch]   = rdata_s;
    assign cnt_a[ch]     = cnt_r;
    assign cnt_nxt_a[ch] = cnt_nxt_s;
    assign drop_a[ch]    = push_a[ch] && (cnt_r == CNT_FULL);
  end

  assign src_acc_s = ss_xfer0 && !drop_a[0];

  // Flags are registered from next-state occupancy so they track the counters cycle for cycle
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || m_reset) begin
      m_src_empty        <= 1'b1;
      m_src_almost_empty <= 1'b1;
      ss_stop0           <= 1'b0;
      ss_start0          <= 1'b1;
      m_dst_full         <= 1'b0;
      m_dst_almost_full  <= 1'b0;
      ss_stop1           <= 1'b0;
      ss_start1          <= 1'b0;
      ovf                <= 1'b0;
      ss_end0            <= 1'b0;
      word_cnt_r         <= 24'd0;
    end else begin
      m_src_empty        <= (cnt_nxt_a[0] == CNT_ZERO);
      m_src_almost_empty <= (cnt_nxt_a[0] <= CNT_ONE);
      ss_stop0           <= (cnt_nxt_a[0] >= CNT_AFULL);
      ss_start0          <= (cnt_nxt_a[0] < CNT_START);
      m_dst_full         <= (cnt_nxt_a[1] == CNT_FULL);
      m_dst_almost_full  <= (cnt_nxt_a[1] >= CNT_AFULL);
      ss_stop1           <= (cnt_nxt_a[1] >= CNT_AFULL);
      ss_start1          <= (cnt_nxt_a[1] >= CNT_START) ||
                            (!m_endn && (cnt_nxt_a[1] != CNT_ZERO));
      ovf                <= ovf || drop_a[0] || drop_a[1];
      ss_end0            <= ss_end0 || ((dc != 24'd0) && (word_cnt_r == dc));
      if (src_acc_s && ((dc == 24'd0) || (word_cnt_r < dc))) begin
        word_cnt_r <= word_cnt_r + 24'd1;
      end
    end
  end

  assign m_src      = rdata_a[0][DW-1:0];
  assign m_src_last = rdata_a[0][DW];
  assign ss_dat1    = rdata_a[1][DW-1:0];
  assign ss_end1    = rdata_a[1][DW];
  assign src_cnt    = cnt_a[0];
  assign dst_cnt    = cnt_a[1];

endmodule
